// File: rtl/axilwr2wbsp_pkg.sv
// Shared definitions for the AXI-lite to Wishbone bridges: response codes,
// width helper and the Wishbone request record.
package axil2wb_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam int WB_MAX_AW = 64;
    localparam int WB_MAX_DW = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    typedef struct packed {
        logic [WB_MAX_AW-1:0]   addr;
        logic [WB_MAX_DW-1:0]   data;
        logic [WB_MAX_DW/8-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/axilwr2wbsp_wr_resp_fifo.sv
// Synchronous 1-bit FIFO holding the error flag of each pending B response.
module wr_resp_fifo
    import axil2wb_pkg::*;
#(
    parameter int LGFLEN = 3
)(
    input  logic              i_clk,
    input  logic              w_reset,
    input  logic              i_push,
    input  logic              i_data,
    input  logic              i_pop,
    output logic              o_data,
    output logic [LGFLEN:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int FLEN = 1 << LGFLEN;

    logic              mem [FLEN];
    logic [LGFLEN-1:0] wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign o_full  = (o_count == (LGFLEN+1)'(FLEN));
    assign o_empty = (o_count == '0);
    assign o_data  = mem[rd_ptr];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk)
        if (do_push)
            mem[wr_ptr] <= i_data;

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/axilwr2wbsp.sv
// AXI-lite write channel to Wishbone pipelined write bridge with in-order B responses.
// Build option AXILWR2WB_LOWPOWER_EN zeroes the WB address/data/select while idle.
module axilwr2wbsp
    import axil2wb_pkg::*;
#(
    parameter int  C_AXI_DATA_WIDTH = 32,
    parameter int  C_AXI_ADDR_WIDTH = 28,
    parameter int  LGFIFO           = 3,
    localparam int DW               = C_AXI_DATA_WIDTH,
    localparam int AXI_LSBS         = clog2(C_AXI_DATA_WIDTH/8),
    localparam int AW               = C_AXI_ADDR_WIDTH - AXI_LSBS
)(
    input  logic            i_clk,
    input  logic            w_reset,
    input  logic            i_axi_awvalid,
    output logic            o_axi_awready,
    input  logic [AW-1:0]   i_axi_awaddr,
    input  logic [2:0]      i_axi_awprot,
    input  logic            i_axi_wvalid,
    output logic            o_axi_wready,
    input  logic [DW-1:0]   i_axi_wdata,
    input  logic [DW/8-1:0] i_axi_wstrb,
    output logic            o_axi_bvalid,
    input  logic            i_axi_bready,
    output logic [1:0]      o_axi_bresp,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err
);

    localparam int FLEN = 1 << LGFIFO;
    localparam int SW   = DW / 8;

    logic            aw_held, w_held;
    logic [AW-1:0]   aw_addr_h;
    logic [DW-1:0]   w_data_h;
    logic [SW-1:0]   w_strb_h;
    logic            err_state;
    logic [LGFIFO:0] inflight, flush_cnt, fifo_count, pending, flush_start;
    logic [LGFIFO+1:0] committed;
    logic            aw_acc, w_acc, bus_ack, bus_err, stb_go, credit_ok, issue, stb_nxt;
    logic            fifo_push, fifo_full, fifo_empty, fifo_head;
    logic            unused_ok;

    assign o_axi_awready = !aw_held && !err_state;
    assign o_axi_wready  = !w_held && !err_state;
    assign o_wb_we       = 1'b1;
    assign o_wb_cyc      = o_wb_stb || (inflight != '0);

    assign aw_acc  = i_axi_awvalid && o_axi_awready;
    assign w_acc   = i_axi_wvalid && o_axi_wready;
    assign bus_err = i_wb_err && o_wb_cyc;
    assign bus_ack = i_wb_ack && o_wb_cyc && !i_wb_err;
    assign stb_go  = o_wb_stb && !i_wb_stall;

    // Every write holds one credit from issue until its B response is popped
    assign committed = {1'b0, inflight} + {1'b0, fifo_count} + (LGFIFO+2)'(o_wb_stb);
    assign credit_ok = committed < (LGFIFO+2)'(FLEN);
    assign issue     = (aw_held || aw_acc) && (w_held || w_acc)
                    && (!o_wb_stb || !i_wb_stall) && !err_state && !bus_err && credit_ok;

    // A strobe still pending on error is abandoned, so it is owed a SLVERR as well
    assign pending     = inflight + (LGFIFO+1)'(o_wb_stb);
    assign flush_start = (pending == '0) ? '0 : pending - 1'b1;

    always_comb begin
        stb_nxt = o_wb_stb;
        if (bus_err)
            stb_nxt = 1'b0;
        else if (issue)
            stb_nxt = 1'b1;
        else if (!i_wb_stall)
            stb_nxt = 1'b0;
    end

    // Skid stage: park an address or data beat that cannot issue yet
    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            aw_held   <= 1'b0;
            aw_addr_h <= '0;
        end else if (issue) begin
            aw_held   <= 1'b0;
        end else if (aw_acc) begin
            aw_held   <= 1'b1;
            aw_addr_h <= i_axi_awaddr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            w_held   <= 1'b0;
            w_data_h <= '0;
            w_strb_h <= '0;
        end else if (issue) begin
            w_held   <= 1'b0;
        end else if (w_acc) begin
            w_held   <= 1'b1;
            w_data_h <= i_axi_wdata;
            w_strb_h <= i_axi_wstrb;
        end
    end

    // Bus stage: request registers seen by the WB slave
    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            o_wb_addr <= '0;
            o_wb_data <= '0;
            o_wb_sel  <= '0;
        end else if (issue) begin
            o_wb_addr <= aw_held ? aw_addr_h : i_axi_awaddr;
            o_wb_data <= w_held  ? w_data_h  : i_axi_wdata;
            o_wb_sel  <= w_held  ? w_strb_h  : i_axi_wstrb;
        end
`ifdef AXILWR2WB_LOWPOWER_EN
        else if (!stb_nxt) begin
            o_wb_addr <= '0;
            o_wb_data <= '0;
            o_wb_sel  <= '0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            o_wb_stb  <= 1'b0;
            inflight  <= '0;
            err_state <= 1'b0;
            flush_cnt <= '0;
        end else begin
            o_wb_stb <= stb_nxt;
            if (bus_err) begin
                inflight  <= '0;
                err_state <= 1'b1;
                flush_cnt <= flush_start;
            end else begin
                case ({stb_go, bus_ack})
                    2'b10:   inflight <= inflight + 1'b1;
                    2'b01:   inflight <= inflight - 1'b1;
                    default: inflight <= inflight;
                endcase
                if (err_state) begin
                    if (flush_cnt != '0)
                        flush_cnt <= flush_cnt - 1'b1;
                    else
                        err_state <= 1'b0;
                end
            end
        end
    end

    // Response stage: error flags queued in issue order
    assign fifo_push = bus_ack || bus_err || (err_state && flush_cnt != '0);

    wr_resp_fifo #(.LGFLEN(LGFIFO)) u_bfifo (
        .i_clk   (i_clk),
        .w_reset (w_reset),
        .i_push  (fifo_push),
        .i_data  (!bus_ack),
        .i_pop   (o_axi_bvalid && i_axi_bready),
        .o_data  (fifo_head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_axi_bvalid = !fifo_empty;
    assign o_axi_bresp  = (fifo_head && !fifo_empty) ? BRESP_SLVERR : BRESP_OKAY;

    assign unused_ok = &{1'b0, i_axi_awprot, fifo_full};

endmodule

// File: tb/tb_axilwr2wbsp.sv
// Directed bench for axilwr2wbsp; honours AXILWR2WB_LOWPOWER_EN when defined.
module tb_axilwr2wbsp;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int SW = DW / 8;
`ifdef AXILWR2WB_LOWPOWER_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          w_reset;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp;
    logic          cyc, stb, we, stall, ack, err;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [SW-1:0] wb_sel;

    int checks = 0;
    int errors = 0;
    int mon_cnt = 0;
    bit mon_en = 1'b0;

    always #5 i_clk = ~i_clk;

    axilwr2wbsp dut (
        .i_clk         (i_clk),
        .w_reset       (w_reset),
        .i_axi_awvalid (awvalid),
        .o_axi_awready (awready),
        .i_axi_awaddr  (awaddr),
        .i_axi_awprot  (awprot),
        .i_axi_wvalid  (wvalid),
        .o_axi_wready  (wready),
        .i_axi_wdata   (wdata),
        .i_axi_wstrb   (wstrb),
        .o_axi_bvalid  (bvalid),
        .i_axi_bready  (bready),
        .o_axi_bresp   (bresp),
        .o_wb_cyc      (cyc),
        .o_wb_stb      (stb),
        .o_wb_we       (we),
        .o_wb_addr     (wb_addr),
        .o_wb_data     (wb_data),
        .o_wb_sel      (wb_sel),
        .i_wb_stall    (stall),
        .i_wb_ack      (ack),
        .i_wb_err      (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    // Every accepted strobe of the burst test must carry the next address in sequence
    always @(negedge i_clk) begin
        if (mon_en && !w_reset && stb && !stall) begin
            chk("burst_addr", 64'(wb_addr), 64'('h100 + mon_cnt));
            chk("burst_data", 64'(wb_data), 64'('hA000 + mon_cnt));
            mon_cnt++;
        end
    end

    initial begin
        int r, n, nresp, acked;
        w_reset = 1'b1; awvalid = 0; awaddr = '0; awprot = '0; wvalid = 0;
        wdata = '0; wstrb = '0; bready = 1'b1; stall = 0; ack = 0; err = 0;
        next(); next();
        smp();
        chk("rst_awready", 64'(awready), 1);
        chk("rst_wready",  64'(wready), 1);
        chk("rst_bvalid",  64'(bvalid), 0);
        chk("rst_bresp",   64'(bresp), 0);
        chk("rst_cyc",     64'(cyc), 0);
        chk("rst_stb",     64'(stb), 0);
        chk("rst_we",      64'(we), 1);
        chk("rst_addr",    64'(wb_addr), 0);
        chk("rst_sel",     64'(wb_sel), 0);
        w_reset = 1'b0;
        next();

        // simultaneous AW and W on an idle bus
        awvalid = 1; awaddr = 'h10; wvalid = 1; wdata = 'hDEADBEEF; wstrb = 'hF;
        smp(); chk("t1_awready", 64'(awready), 1);
        next();
        awvalid = 0; wvalid = 0;
        smp();
        chk("t1_stb", 64'(stb), 1); chk("t1_cyc", 64'(cyc), 1);
        chk("t1_addr", 64'(wb_addr), 'h10); chk("t1_data", 64'(wb_data), 'hDEADBEEF);
        chk("t1_sel", 64'(wb_sel), 'hF);
        next();
        ack = 1;
        smp(); chk("t1_stb_drop", 64'(stb), 0); chk("t1_bvalid_early", 64'(bvalid), 0);
        next();
        ack = 0;
        smp();
        chk("t1_bvalid", 64'(bvalid), 1); chk("t1_bresp", 64'(bresp), 0);
        chk("t1_cyc_idle", 64'(cyc), 0);
        chk("t1_idle_addr", 64'(wb_addr), LP ? 64'h0 : 64'h10);
        chk("t1_idle_data", 64'(wb_data), LP ? 64'h0 : 64'hDEADBEEF);
        chk("t1_idle_sel", 64'(wb_sel), LP ? 64'h0 : 64'hF);
        next();
        smp(); chk("t1_bvalid_pop", 64'(bvalid), 0);
        next();

        // W arrives three cycles before AW
        wvalid = 1; wdata = 'h1234; wstrb = 'h3;
        smp(); chk("t2_wready", 64'(wready), 1);
        next();
        wvalid = 0;
        smp(); chk("t2_wready_held", 64'(wready), 0); chk("t2_no_stb", 64'(stb), 0);
        next();
        smp(); next();
        awvalid = 1; awaddr = 'h20;
        smp(); chk("t2_awready", 64'(awready), 1);
        next();
        awvalid = 0;
        smp();
        chk("t2_stb", 64'(stb), 1); chk("t2_addr", 64'(wb_addr), 'h20);
        chk("t2_data", 64'(wb_data), 'h1234); chk("t2_sel", 64'(wb_sel), 'h3);
        chk("t2_wready_free", 64'(wready), 1);
        next();
        ack = 1;
        smp(); chk("t2_single_stb", 64'(stb), 0);
        next();
        ack = 0;
        smp(); chk("t2_bvalid", 64'(bvalid), 1); chk("t2_bresp", 64'(bresp), 0);
        next();
        smp(); chk("t2_bvalid_pop", 64'(bvalid), 0);
        next();

        // nine writes: stall first, then credit exhaustion with bready low
        bready = 0; mon_en = 1'b1; r = 0; n = 0;
        while (r < 9 && n < 60) begin
            awvalid = 1; wvalid = 1; awaddr = AW'('h100 + r);
            wdata = DW'('hA000 + r); wstrb = 'hF; stall = (n < 4);
            smp();
            if (awvalid && awready) r++;
            n++;
            next();
        end
        awvalid = 0; wvalid = 0; stall = 0;
        chk("t3_feed", 64'(r), 9);
        n = 0;
        while (mon_cnt < 8 && n < 20) begin smp(); n++; next(); end
        chk("t3_issued8", 64'(mon_cnt), 8);
        smp(); chk("t3_credit_stb", 64'(stb), 0); chk("t3_credit_awready", 64'(awready), 0);
        next();
        for (int i = 0; i < 8; i++) begin
            ack = 1;
            smp(); next();
        end
        ack = 0;
        smp();
        chk("t3_full_bvalid", 64'(bvalid), 1); chk("t3_full_stb", 64'(stb), 0);
        chk("t3_full_awready", 64'(awready), 0); chk("t3_full_cyc", 64'(cyc), 0);
        next();
        bready = 1; nresp = 0; acked = 8; n = 0;
        while (nresp < 9 && n < 40) begin
            ack = (mon_cnt > acked);
            if (ack) acked++;
            smp();
            if (bvalid) begin
                chk("t3_bresp", 64'(bresp), 0);
                nresp++;
            end
            n++;
            next();
        end
        ack = 0; mon_en = 1'b0;
        chk("t3_nresp", 64'(nresp), 9);
        chk("t3_nstb", 64'(mon_cnt), 9);
        smp(); next();

        // three writes, the second one errors
        bready = 0;
        for (int i = 0; i < 3; i++) begin
            awvalid = 1; wvalid = 1; awaddr = AW'('h200 + i); wdata = DW'(i); wstrb = 'hF;
            smp(); chk("t4_awready", 64'(awready), 1);
            next();
        end
        awvalid = 0; wvalid = 0;
        smp(); next();
        ack = 1;
        smp(); chk("t4_cyc_ack", 64'(cyc), 1);
        next();
        ack = 0; err = 1;
        smp(); chk("t4_cyc_err", 64'(cyc), 1);
        next();
        err = 0;
        smp();
        chk("t4_cyc_drop", 64'(cyc), 0); chk("t4_stb_drop", 64'(stb), 0);
        chk("t4_awready_flush", 64'(awready), 0); chk("t4_wready_flush", 64'(wready), 0);
        next();
        smp(); chk("t4_awready_flush2", 64'(awready), 0);
        next();
        bready = 1;
        smp();
        chk("t4_awready_exit", 64'(awready), 1);
        chk("t4_b0_valid", 64'(bvalid), 1); chk("t4_b0_resp", 64'(bresp), 0);
        next();
        smp(); chk("t4_b1_valid", 64'(bvalid), 1); chk("t4_b1_resp", 64'(bresp), 2);
        next();
        smp(); chk("t4_b2_valid", 64'(bvalid), 1); chk("t4_b2_resp", 64'(bresp), 2);
        next();
        smp(); chk("t4_b_empty", 64'(bvalid), 0);
        next();

        // reset while a strobe is stalled and a response is queued
        bready = 0;
        awvalid = 1; wvalid = 1; awaddr = 'h300; wdata = 'h55; wstrb = 'h1;
        smp(); next();
        awvalid = 0; wvalid = 0;
        smp(); next();
        ack = 1;
        smp(); next();
        ack = 0; stall = 1;
        awvalid = 1; wvalid = 1; awaddr = 'h301; wdata = 'h66; wstrb = 'h2;
        smp(); next();
        awvalid = 0; wvalid = 0; w_reset = 1;
        smp(); chk("t5_stb_pre", 64'(stb), 1); chk("t5_bvalid_pre", 64'(bvalid), 1);
        next();
        w_reset = 0; stall = 0;
        smp();
        chk("t5_cyc", 64'(cyc), 0); chk("t5_stb", 64'(stb), 0);
        chk("t5_bvalid", 64'(bvalid), 0); chk("t5_awready", 64'(awready), 1);
        chk("t5_wready", 64'(wready), 1); chk("t5_addr", 64'(wb_addr), 0);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
